// File: rtl/hms_bcd_convert.sv
// Sequential seconds-to-HH:MM:SS BCD converter for the seven-segment display path.
// Repeated subtraction counts hours and minutes, then a compare ladder splits each field.
module hms_bcd_convert (
    input  logic        clk,
    input  logic        reset,
    input  logic [16:0] total_sec,
    input  logic        flash_hh_in,
    input  logic        flash_mm_in,
    input  logic        flash_ss_in,
    output logic [3:0]  hh_tens,
    output logic [3:0]  hh_ones,
    output logic [3:0]  mm_tens,
    output logic [3:0]  mm_ones,
    output logic [3:0]  ss_tens,
    output logic [3:0]  ss_ones,
    output logic        blank_hh,
    output logic        blank_mm,
    output logic        blank_ss,
    output logic        busy,
    output logic        upd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOURS = 2'd1,
        MINS  = 2'd2,
        SPLIT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [16:0] last_sec;
    logic [16:0] rem;
    logic [5:0]  hrs;
    logic [5:0]  mins;
    logic [7:0]  hh_bcd;
    logic [7:0]  mm_bcd;
    logic [7:0]  ss_bcd;

    // Tens/ones split of a field below 60 (hours never exceed 36).
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] base;
        tens = 4'd0;
        base = 6'd0;
        if (v >= 6'd50) begin
            tens = 4'd5;
            base = 6'd50;
        end else if (v >= 6'd40) begin
            tens = 4'd4;
            base = 6'd40;
        end else if (v >= 6'd30) begin
            tens = 4'd3;
            base = 6'd30;
        end else if (v >= 6'd20) begin
            tens = 4'd2;
            base = 6'd20;
        end else if (v >= 6'd10) begin
            tens = 4'd1;
            base = 6'd10;
        end
        return {tens, 4'(v - base)};
    endfunction

    assign hh_bcd = to_bcd(hrs);
    assign mm_bcd = to_bcd(mins);
    assign ss_bcd = to_bcd(6'(rem));
    assign busy   = (state != IDLE);

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (total_sec != last_sec) state_next = HOURS;
            HOURS:   if (rem < 17'd3600) state_next = MINS;
            MINS:    if (rem < 17'd60) state_next = SPLIT;
            SPLIT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            last_sec <= 17'd0;
            rem      <= 17'd0;
            hrs      <= 6'd0;
            mins     <= 6'd0;
            hh_tens  <= 4'd0;
            hh_ones  <= 4'd0;
            mm_tens  <= 4'd0;
            mm_ones  <= 4'd0;
            ss_tens  <= 4'd0;
            ss_ones  <= 4'd0;
            upd      <= 1'b0;
        end else begin
            upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (total_sec != last_sec) begin
                        last_sec <= total_sec;
                        rem      <= total_sec;
                        hrs      <= 6'd0;
                        mins     <= 6'd0;
                    end
                end
                HOURS: begin
                    if (rem >= 17'd3600) begin
                        rem <= rem - 17'd3600;
                        hrs <= hrs + 6'd1;
                    end
                end
                MINS: begin
                    if (rem >= 17'd60) begin
                        rem  <= rem - 17'd60;
                        mins <= mins + 6'd1;
                    end
                end
                SPLIT: begin
                    // All six digits move on this one edge so the display never tears.
                    {hh_tens, hh_ones} <= hh_bcd;
                    {mm_tens, mm_ones} <= mm_bcd;
                    {ss_tens, ss_ones} <= ss_bcd;
                    upd                <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Flash requests bypass the converter: plain one-cycle register.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            blank_hh <= 1'b0;
            blank_mm <= 1'b0;
            blank_ss <= 1'b0;
        end else begin
            blank_hh <= flash_hh_in;
            blank_mm <= flash_mm_in;
            blank_ss <= flash_ss_in;
        end
    end

endmodule

// File: tb/tb_hms_bcd_convert.sv
// Directed-vector bench for hms_bcd_convert; DUT registers on the falling edge,
// so the bench drives and samples on the rising edge.
module tb_hms_bcd_convert;

    logic        clk;
    logic        reset;
    logic [16:0] total_sec;
    logic        flash_hh_in;
    logic        flash_mm_in;
    logic        flash_ss_in;
    logic [3:0]  hh_tens, hh_ones, mm_tens, mm_ones, ss_tens, ss_ones;
    logic        blank_hh, blank_mm, blank_ss;
    logic        busy;
    logic        upd;
    logic [23:0] digits;

    int n_checks = 0;
    int n_fail   = 0;

    hms_bcd_convert dut (
        .clk         (clk),
        .reset       (reset),
        .total_sec   (total_sec),
        .flash_hh_in (flash_hh_in),
        .flash_mm_in (flash_mm_in),
        .flash_ss_in (flash_ss_in),
        .hh_tens     (hh_tens),
        .hh_ones     (hh_ones),
        .mm_tens     (mm_tens),
        .mm_ones     (mm_ones),
        .ss_tens     (ss_tens),
        .ss_ones     (ss_ones),
        .blank_hh    (blank_hh),
        .blank_mm    (blank_mm),
        .blank_ss    (blank_ss),
        .busy        (busy),
        .upd         (upd)
    );

    assign digits = {hh_tens, hh_ones, mm_tens, mm_ones, ss_tens, ss_ones};

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Counts rising edges until upd is seen; also counts busy cycles and
    // cycles where the digits moved before upd.
    task automatic wait_upd(input int limit, output int cycles, output int busy_cyc,
                            output int early, output bit timed_out);
        logic [23:0] start;
        start     = digits;
        cycles    = 0;
        busy_cyc  = 0;
        early     = 0;
        timed_out = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            cycles++;
            if (busy) busy_cyc++;
            if (upd) begin
                timed_out = 1'b0;
                break;
            end
            if (digits !== start) early++;
        end
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        total_sec   = 17'd0;
        flash_hh_in = 1'b1;
        flash_mm_in = 1'b1;
        flash_ss_in = 1'b1;
        repeat (3) @(posedge clk);
        n_checks++;
        if ({digits, blank_hh, blank_mm, blank_ss, busy, upd} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_state: digits=%h blanks=%b%b%b busy=%b upd=%b, required all 0",
                     digits, blank_hh, blank_mm, blank_ss, busy, upd);
        end
        flash_hh_in = 1'b0;
        flash_mm_in = 1'b0;
        flash_ss_in = 1'b0;
        reset       = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            n_checks++;
            if ({digits, busy, upd} !== 26'd0) begin
                n_fail++;
                $display("FAIL zero_idle cycle %0d: digits=%h busy=%b upd=%b, required 000000/0/0",
                         i, digits, busy, upd);
            end
        end
    endtask

    task automatic test_3661();
        int cyc, bcyc, early, quiet;
        bit to;
        total_sec = 17'd3661;
        wait_upd(200, cyc, bcyc, early, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL t3661_timeout: no upd within 200 cycles, required upd");
        end
        n_checks++;
        if (cyc != 6) begin
            n_fail++;
            $display("FAIL t3661_latency: got %0d cycles, required 6", cyc);
        end
        n_checks++;
        if (bcyc != 5) begin
            n_fail++;
            $display("FAIL t3661_busy: busy high %0d cycles, required 5", bcyc);
        end
        n_checks++;
        if (digits !== 24'h010101) begin
            n_fail++;
            $display("FAIL t3661_digits: got %h, required 010101", digits);
        end
        n_checks++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL t3661_early: digits moved before upd in %0d cycles, required 0", early);
        end
        @(posedge clk);
        n_checks++;
        if (upd !== 1'b0) begin
            n_fail++;
            $display("FAIL t3661_upd_width: upd=%b one cycle after pulse, required 0", upd);
        end
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            if (busy || upd) quiet++;
        end
        n_checks++;
        if (quiet != 0) begin
            n_fail++;
            $display("FAIL t3661_no_rerun: activity in %0d cycles with unchanged input, required 0", quiet);
        end
    endtask

    task automatic test_max_values();
        logic [16:0] vals [2];
        int          lats [2];
        logic [23:0] exps [2];
        int cyc, bcyc, early;
        bit to;
        vals[0] = 17'd86399;  lats[0] = 86; exps[0] = 24'h235959;
        vals[1] = 17'd131071; lats[1] = 64; exps[1] = 24'h362431;
        for (int k = 0; k < 2; k++) begin
            total_sec = vals[k];
            wait_upd(200, cyc, bcyc, early, to);
            n_checks++;
            if (to || cyc != lats[k]) begin
                n_fail++;
                $display("FAIL max_latency %0d: got %0d cycles (timeout=%b), required %0d",
                         vals[k], cyc, to, lats[k]);
            end
            n_checks++;
            if (digits !== exps[k]) begin
                n_fail++;
                $display("FAIL max_digits %0d: got %h, required %h", vals[k], digits, exps[k]);
            end
            n_checks++;
            if (early != 0) begin
                n_fail++;
                $display("FAIL max_early %0d: digits moved early in %0d cycles, required 0",
                         vals[k], early);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int          pulses, bad;
        logic [23:0] first;
        total_sec = 17'd59;
        @(posedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_busy: busy=%b after capture, required 1", busy);
        end
        total_sec = 17'd3600;
        pulses = 0;
        bad    = 0;
        first  = 24'h0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            if (upd) begin
                if (pulses == 0) first = digits;
                pulses++;
            end
            if (digits !== 24'h362431 && digits !== 24'h000059 && digits !== 24'h010000) bad++;
        end
        n_checks++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d upd pulses, required 2", pulses);
        end
        n_checks++;
        if (first !== 24'h000059) begin
            n_fail++;
            $display("FAIL b2b_first: first result %h, required 000059", first);
        end
        n_checks++;
        if (digits !== 24'h010000) begin
            n_fail++;
            $display("FAIL b2b_second: final digits %h, required 010000", digits);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL b2b_mixed: %0d cycles showed a mixed value, required 0", bad);
        end
    endtask

    task automatic test_flash();
        int cyc, bcyc, early;
        bit to;
        flash_mm_in = 1'b1;
        #1;
        n_checks++;
        if (blank_mm !== 1'b0) begin
            n_fail++;
            $display("FAIL flash_latency: blank_mm=%b before clock edge, required 0", blank_mm);
        end
        @(posedge clk);
        n_checks++;
        if ({blank_hh, blank_mm, blank_ss} !== 3'b010) begin
            n_fail++;
            $display("FAIL flash_idle_on: blanks=%b%b%b, required 010", blank_hh, blank_mm, blank_ss);
        end
        flash_mm_in = 1'b0;
        @(posedge clk);
        n_checks++;
        if ({blank_hh, blank_mm, blank_ss} !== 3'b000) begin
            n_fail++;
            $display("FAIL flash_idle_off: blanks=%b%b%b, required 000", blank_hh, blank_mm, blank_ss);
        end
        total_sec = 17'd86399;
        @(posedge clk);
        flash_mm_in = 1'b1;
        @(posedge clk);
        n_checks++;
        if ({blank_hh, blank_mm, blank_ss, busy} !== 4'b0101) begin
            n_fail++;
            $display("FAIL flash_busy_on: blanks=%b%b%b busy=%b, required 010 busy 1",
                     blank_hh, blank_mm, blank_ss, busy);
        end
        flash_mm_in = 1'b0;
        @(posedge clk);
        n_checks++;
        if ({blank_hh, blank_mm, blank_ss} !== 3'b000) begin
            n_fail++;
            $display("FAIL flash_busy_off: blanks=%b%b%b, required 000", blank_hh, blank_mm, blank_ss);
        end
        wait_upd(200, cyc, bcyc, early, to);
        n_checks++;
        if (to || digits !== 24'h235959) begin
            n_fail++;
            $display("FAIL flash_conv: digits=%h timeout=%b, required 235959", digits, to);
        end
        @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc, bcyc, early;
        bit to;
        flash_ss_in = 1'b1;
        total_sec   = 17'd7322;
        repeat (3) @(posedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({digits, blank_hh, blank_mm, blank_ss, busy, upd} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: digits=%h blanks=%b%b%b busy=%b upd=%b, required all 0",
                     digits, blank_hh, blank_mm, blank_ss, busy, upd);
        end
        flash_ss_in = 1'b0;
        repeat (2) @(posedge clk);
        reset = 1'b1;
        wait_upd(200, cyc, bcyc, early, to);
        n_checks++;
        if (to || cyc != 8) begin
            n_fail++;
            $display("FAIL reset_mid_latency: got %0d cycles (timeout=%b), required 8", cyc, to);
        end
        n_checks++;
        if (digits !== 24'h020202) begin
            n_fail++;
            $display("FAIL reset_mid_digits: got %h, required 020202", digits);
        end
    endtask

    initial begin
        test_reset();
        test_3661();
        test_max_values();
        test_back_to_back();
        test_flash();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
